ad_avg_peak_tracker: RTL and testbench
======================================

Name: ad_avg_peak_tracker

Overview:
- Front-end conditioning stage on the AD sample clock, directly upstream of the square/sine wave classifier.
- Smooths the raw 8-bit AD stream with a power-of-two moving-average filter.
- Tracks per-frame maximum and minimum of the smoothed stream and publishes them as the frame amplitude bounds.
- Outputs ad_avg_data, ad_max and ad_min are the classifier's data, max and min inputs; signal_present gates downstream use of the result.

Parameters:
- AVG_SHIFT, 2: averaging window W = 2^AVG_SHIFT samples; legal range 1..4.
- FRAME_LEN, 1024: number of averaged samples per peak-tracking frame; legal range 2..65535.
- MIN_SPAN, 20: minimum published (max - min) for signal_present to assert.

Ports:
- clk  in  1  AD sample clock (ad_clk); every rising edge carries one sample.
- rst_n  in  1  asynchronous active-low reset.
- ad_data  in  8  raw unsigned AD sample.
- ad_avg_data  out  8  moving-average output (registered).
- avg_valid  out  1  high once the averaging window is fully populated.
- ad_max  out  8  maximum of ad_avg_data over the last completed frame.
- ad_min  out  8  minimum of ad_avg_data over the last completed frame.
- peak_valid  out  1  one-cycle pulse when ad_max/ad_min are updated.
- signal_present  out  1  registered; (ad_max - ad_min) >= MIN_SPAN for the last completed frame.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - ad_avg_data = 0, avg_valid = 0, peak_valid = 0, signal_present = 0.
  - ad_max = 8'd255 and ad_min = 8'd0, giving the downstream the widest thresholds before the first frame completes.
  - Internal state cleared: sample delay line, running sum, fill counter, frame counter.
  - Running max = 0, running min = 255, state = S_FILL.
- Averaging datapath:
  - Delay line of W samples; running sum is (8 + AVG_SHIFT) bits wide.
  - Each edge: sum <= sum + ad_data - oldest, with oldest = sample captured W edges earlier (0 during fill).
  - Next edge: ad_avg_data <= sum >> AVG_SHIFT, i.e. truncating floor.
  - Latency: a sample presented before edge k first affects ad_avg_data after edge k+1.
  - No overflow is possible by construction; no saturation logic is required.
- State machine:
  - S_FILL: counts captured samples. When the W-th sample is captured, go to S_TRACK. avg_valid goes high on the same edge that ad_avg_data first reflects a full window.
  - S_TRACK: avg_valid stays high. Each cycle with avg_valid = 1, ad_avg_data feeds the frame tracker.
  - No other exit: only reset returns the block to S_FILL.
- Frame tracker:
  - Frame counter counts 0..FRAME_LEN-1 over tracked samples.
  - Each tracked sample updates running max/min.
  - On the sample where count = FRAME_LEN-1, publish on the next edge:
    - ad_max/ad_min take the running max/min including that sample.
    - peak_valid pulses high for exactly 1 cycle.
    - signal_present <= (max - min >= MIN_SPAN), computed from the values being published.
  - On the same edge, the counter wraps to 0, running max reseeds to 0 and running min to 255.
  - No sample is dropped across the frame boundary: the first sample of the next frame is tracked on the cycle after the last sample of the previous frame.
- Invariants and boundaries:
  - ad_min <= ad_max holds after every publish.
  - ad_max/ad_min hold their values between publishes.
  - A constant input publishes max = min = that value, and signal_present = 0 (given MIN_SPAN > 0).
  - Values 0 and 255 are tracked correctly; no reserved codes.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). The partial frame is discarded. After release, the S_FILL refill of W samples is required before tracking resumes.

Test Plan:
- Reset then constant ad_data = 100, AVG_SHIFT = 2 -> avg_valid rises after the 4th sample edge + 1. ad_avg_data = 100 from then on. ad_max = 255 and ad_min = 0 until the first peak_valid.
- Step 0 -> 200 after fill -> ad_avg_data steps 50, 100, 150, 200 on consecutive cycles. Verify floor truncation with input 1,2,2,2 -> 1.
- FRAME_LEN = 16, repeating 16-sample ramp 10..160 step 10 after fill -> peak_valid one cycle every 16 tracked samples. Published max/min equal the true extremes of the averaged ramp in that frame. signal_present = 1.
- Constant 128 for 2 frames, FRAME_LEN = 16 -> ad_max = ad_min = 128 and signal_present = 0 at each publish. Then a square 0/255 with 8-sample half period -> next publish ad_max = 255, ad_min = 0, signal_present = 1.
- Extreme value placed on the last sample of a frame, and a different one on the first sample of the next frame -> each lands in its own frame's published result.
- Assert rst_n low mid-frame (sample 7 of 16) -> outputs return to reset values at once. After release, avg_valid is low for W cycles and the first peak_valid comes 16 tracked samples later.

Source files
------------

// File: rtl/ad_avg_peak_tracker.sv
// ad_avg_peak_tracker: moving-average smoothing of the AD stream plus per-frame max/min publishing
module ad_avg_peak_tracker #(
  parameter int AVG_SHIFT = 2,
  parameter int FRAME_LEN = 1024,
  parameter int MIN_SPAN  = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ad_data,
  output logic [7:0] ad_avg_data,
  output logic       avg_valid,
  output logic [7:0] ad_max,
  output logic [7:0] ad_min,
  output logic       peak_valid,
  output logic       signal_present
);
  localparam int W  = 1 << AVG_SHIFT;
  localparam int SW = 8 + AVG_SHIFT;
  typedef enum logic {S_FILL, S_TRACK} state_t;
  state_t          state, state_nxt;
  logic [7:0]      dl [W];
  logic [SW-1:0]   sum;
  logic [4:0]      fill_cnt;
  logic [15:0]     frm_cnt;
  logic [7:0]      run_max, run_min, new_max, new_min, span;
  logic            track, last;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_FILL;
    else        state <= state_nxt;
  // leave fill once the W-th sample is captured; only reset returns to fill
  always_comb
    state_nxt = (state == S_FILL && fill_cnt == 5'(W - 1)) ? S_TRACK : state;
  // window is full while tracking
  always_comb
    track = (state == S_TRACK);
  // fill counter counts captured samples until the window is populated
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                fill_cnt <= '0;
    else if (state == S_FILL)  fill_cnt <= fill_cnt + 5'd1;
  // delay line and running window sum; zeroed line makes the oldest sample 0 during fill
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < W; i++) dl[i] <= '0;
      sum <= '0;
    end else begin
      dl[0] <= ad_data;
      for (int i = 1; i < W; i++) dl[i] <= dl[i-1];
      sum <= sum + SW'(ad_data) - SW'(dl[W-1]);
    end
  // registered average; valid follows the state one edge later so it aligns with a full-window average
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ad_avg_data <= '0;
      avg_valid   <= 1'b0;
    end else begin
      ad_avg_data <= 8'(sum >> AVG_SHIFT);
      avg_valid   <= track;
    end
  // running extremes including the current averaged sample
  always_comb begin
    new_max = (ad_avg_data > run_max) ? ad_avg_data : run_max;
    new_min = (ad_avg_data < run_min) ? ad_avg_data : run_min;
    span    = new_max - new_min;
    last    = avg_valid && frm_cnt == 16'(FRAME_LEN - 1);
  end
  // frame tracker: accumulate extremes, publish and reseed on the last sample of a frame
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      frm_cnt        <= '0;
      run_max        <= 8'd0;
      run_min        <= 8'd255;
      ad_max         <= 8'd255;
      ad_min         <= 8'd0;
      peak_valid     <= 1'b0;
      signal_present <= 1'b0;
    end else begin
      peak_valid <= last;
      if (last) begin
        frm_cnt        <= '0;
        run_max        <= 8'd0;
        run_min        <= 8'd255;
        ad_max         <= new_max;
        ad_min         <= new_min;
        signal_present <= 32'(span) >= 32'(MIN_SPAN);
      end else if (avg_valid) begin
        frm_cnt <= frm_cnt + 16'd1;
        run_max <= new_max;
        run_min <= new_min;
      end
    end
endmodule

// File: tb/tb_ad_avg_peak_tracker.sv
// tb_ad_avg_peak_tracker: scoreboard bench for the averaging and peak tracking stage
module tb_ad_avg_peak_tracker;
  localparam int AS = 2;
  localparam int W  = 1 << AS;
  localparam int FL = 16;
  localparam int MS = 20;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ad_data = '0;
  logic [7:0] ad_avg_data, ad_max, ad_min;
  logic       avg_valid, peak_valid, signal_present;
  typedef struct packed {logic [7:0] avg; logic v;} avg_t;
  typedef struct packed {logic pv; logic [7:0] mx; logic [7:0] mn; logic sp;} pk_t;
  avg_t aq[$];
  pk_t  pq[$];
  int checks = 0, errors = 0;
  int win [W];
  int nsamp, fcnt, rmax, rmin, pmax, pmin, psp;

  ad_avg_peak_tracker #(.AVG_SHIFT(AS), .FRAME_LEN(FL), .MIN_SPAN(MS)) dut (
    .clk(clk), .rst_n(rst_n), .ad_data(ad_data), .ad_avg_data(ad_avg_data),
    .avg_valid(avg_valid), .ad_max(ad_max), .ad_min(ad_min),
    .peak_valid(peak_valid), .signal_present(signal_present)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < W; i++) win[i] = 0;
    nsamp = 0; fcnt = 0; rmax = 0; rmin = 255; pmax = 255; pmin = 0; psp = 0;
    aq.delete();
    pq.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_avg"},   32'(ad_avg_data), 0);
    check({tag, "_avgv"},  32'(avg_valid), 0);
    check({tag, "_max"},   32'(ad_max), 255);
    check({tag, "_min"},   32'(ad_min), 0);
    check({tag, "_pv"},    32'(peak_valid), 0);
    check({tag, "_sp"},    32'(signal_present), 0);
  endtask

  // drive one sample, push expected results, then compare whatever is due after the edge
  task automatic step(input int v);
    int s, e;
    logic pv;
    avg_t a;
    pk_t  p;
    ad_data = 8'(v);
    for (int i = W - 1; i > 0; i--) win[i] = win[i-1];
    win[0] = v;
    s = 0;
    for (int i = 0; i < W; i++) s += win[i];
    e = s >> AS;
    nsamp++;
    aq.push_back('{avg: 8'(e), v: (nsamp >= W)});
    pv = 1'b0;
    if (nsamp >= W) begin
      if (e > rmax) rmax = e;
      if (e < rmin) rmin = e;
      if (fcnt == FL - 1) begin
        pv = 1'b1; pmax = rmax; pmin = rmin; psp = (pmax - pmin >= MS) ? 1 : 0;
        rmax = 0; rmin = 255; fcnt = 0;
      end else fcnt++;
    end
    pq.push_back('{pv: pv, mx: 8'(pmax), mn: 8'(pmin), sp: psp[0]});
    @(posedge clk);
    #1;
    if (aq.size() == 2) begin
      a = aq.pop_front();
      check("avg_data",  32'(ad_avg_data), 32'(a.avg));
      check("avg_valid", 32'(avg_valid),   32'(a.v));
    end
    if (pq.size() == 3) begin
      p = pq.pop_front();
      check("peak_valid",     32'(peak_valid),     32'(p.pv));
      check("ad_max",         32'(ad_max),         32'(p.mx));
      check("ad_min",         32'(ad_min),         32'(p.mn));
      check("signal_present", 32'(signal_present), 32'(p.sp));
      if (p.pv) check("min_le_max", 32'(ad_min <= ad_max), 1);
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    // constant fill then steady value
    repeat (12) step(100);
    // flush to zero, then step to 200 gives 50,100,150,200
    repeat (6) step(0);
    repeat (6) step(200);
    // floor truncation: window 1,2,2,2 averages to 1
    repeat (4) step(0);
    step(1); step(2); step(2); step(2);
    // repeating ramp 10..160
    for (int f = 0; f < 3; f++)
      for (int i = 1; i <= 16; i++) step(10 * i);
    // constant 128 for over two frames, then 0/255 square
    repeat (40) step(128);
    for (int i = 0; i < 40; i++) step((i / 8) % 2 ? 255 : 0);
    // extremes straddling a frame boundary
    for (int g = 0; g < 20 && fcnt != FL - 1; g++) step(100);
    step(255);
    step(0);
    repeat (20) step(100);
    // random traffic
    repeat (40) step(int'($urandom_range(0, 255)));
    // asynchronous reset mid-frame
    for (int g = 0; g < 20 && fcnt != 7; g++) step(int'($urandom_range(0, 255)));
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (40) step(int'($urandom_range(50, 150)));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
